pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter and branch-resolution stage of the RISC-V core. It sits directly downstream of the ALU: it consumes the ALU status flags {N,V,Z} from the execute-stage compare (Ain − Bin) and decides whether a branch or jump is taken. It owns the PC register, drives sequential fetch requests to instruction memory through a valid/ready handshake, and redirects and flushes the pipeline on taken control transfers. It also traps on misaligned targets and counts redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned
- FLUSH_CYCLES, 2, cycles of flush after a redirect; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute stage presents a resolved instruction this cycle
- ex_pc  in  32  PC of that instruction
- ex_kind  in  3  000 plain/ALU, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR, 111 treated as 000
- ex_status  in  3  ALU status {N,V,Z} for the compare
- ex_imm  in  32  sign-extended offset
- ex_base  in  32  rs1 value, used by JALR only
- fetch_ready  in  1  instruction memory accepts fetch_pc
- fetch_valid  out  1  fetch request valid
- fetch_pc  out  32  fetch address, registered
- flush  out  1  kill all younger in-flight instructions, registered
- link_pc  out  32  ex_pc + 4, combinational, for JAL/JALR writeback
- trap  out  1  misaligned-target trap, sticky
- trap_pc  out  32  ex_pc of the trapping instruction
- redirect_count  out  16  taken redirects, saturating

## Operation
- FSM states are BOOT, RUN, FLUSH and TRAP. Asynchronous reset enters BOOT.
- BOOT lasts one cycle with fetch_valid = 0, then moves to RUN.
- fetch_valid = 1 only in RUN.
- Sequential fetch in RUN:
  - On fetch_valid & fetch_ready, fetch_pc <= fetch_pc + 4 (mod 2^32).
  - On stall (!fetch_ready), fetch_pc is held stable.
- Taken conditions, evaluated only when ex_valid is high in RUN:
  - BEQ: Z
  - BNE: !Z
  - BLT: N ^ V
  - BGE: !(N ^ V)
  - JAL and JALR: always taken
- Target, all arithmetic 32-bit wraparound:
  - Branches and JAL: ex_pc + ex_imm.
  - JALR: (ex_base + ex_imm) & ~32'h1.
- Taken with target[1:0] == 0 (redirect):
  - fetch_pc <= target.
  - State goes to FLUSH with a down-counter loaded with FLUSH_CYCLES.
  - redirect_count increments, saturating at 16'hFFFF.
- Taken with target[1:0] != 0:
  - State goes to TRAP; trap <= 1 and trap_pc <= ex_pc.
  - No redirect and no count.
- FLUSH:
  - flush = 1 and fetch_valid = 0.
  - ex_valid is ignored, because those instructions are wrong-path.
  - The counter decrements each cycle; when it reaches 0, state goes to RUN.
- TRAP: fetch_valid = 0, flush = 1, all inputs ignored until reset.
- Not-taken or plain instructions have no effect on PC flow.
- Simultaneous redirect and accepted fetch handshake: the redirect wins, fetch_pc <= target, and the accepted word is discarded by flush.
- Reset asserted in any state, including mid-FLUSH or TRAP, immediately returns all outputs to their reset values.
- Reset values:
  - fetch_pc = RESET_PC
  - fetch_valid = 0
  - flush = 0
  - trap = 0
  - trap_pc = 0
  - redirect_count = 0

## Timing
- Taken branch resolved in cycle N (ex_valid high):
  - fetch_pc = target from cycle N+1.
  - flush = 1 and fetch_valid = 0 in cycles N+1 .. N+FLUSH_CYCLES.
  - fetch_valid = 1 with fetch_pc = target in cycle N+FLUSH_CYCLES+1.
- Misaligned taken target in cycle N: trap = 1 and flush = 1 from N+1 onward.
- Sequential fetch: one address per accepted cycle; zero-bubble throughput while fetch_ready is held high.
- After rst_n rises: BOOT in the first cycle, fetch_valid = 1 with fetch_pc = RESET_PC in the second.
- link_pc has zero latency from ex_pc.
- redirect_count updates in cycle N+1.

## Test plan
- Reset release with fetch_ready = 1 for 4 cycles -> fetch_pc shows 0x0, 0x4, 0x8 on the accepted cycles; fetch_valid is low in the BOOT cycle.
- fetch_ready low for 3 cycles at fetch_pc = 0x10 -> fetch_pc held at 0x10 with fetch_valid high; advances to 0x14 after ready returns.
- BEQ with ex_pc = 0x20, ex_imm = 0x40, status Z = 1 -> fetch_pc = 0x60, flush high for 2 cycles, redirect_count = 1.
- BEQ with Z = 0 -> no flush; BLT with N = 1, V = 1 -> not taken; BGE with N = 1, V = 1 -> taken.
- JALR with ex_base = 0x1003, ex_imm = 0 -> target 0x1002, misaligned -> trap = 1, trap_pc = ex_pc, fetch_valid stays low; rst_n pulse clears the trap.
- Redirect coinciding with an accepted fetch, then rst_n asserted mid-FLUSH -> outputs immediately return to reset values.
- Preloaded redirect_count = 0xFFFF plus one further redirect -> count stays 0xFFFF.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program-counter and branch-resolution stage: owns the fetch PC, resolves
// branches/jumps from ALU status flags, flushes on redirects, traps on misaligned targets.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_kind,
    input  logic [2:0]  ex_status,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_base,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        flush,
    output logic [31:0] link_pc,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, TRAP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt;
    logic        taken;
    logic        resolve;
    logic        redirect;
    logic        misalign;
    logic [31:0] target;

    logic st_n, st_v, st_z;
    assign st_n = ex_status[2];
    assign st_v = ex_status[1];
    assign st_z = ex_status[0];

    always_comb begin
        taken = 1'b0;
        case (ex_kind)
            3'b001:         taken = st_z;
            3'b010:         taken = !st_z;
            3'b011:         taken = st_n ^ st_v;
            3'b100:         taken = !(st_n ^ st_v);
            3'b101, 3'b110: taken = 1'b1;
            default:        taken = 1'b0;
        endcase
    end

    assign target   = (ex_kind == 3'b110) ? ((ex_base + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign resolve  = (state == RUN) && ex_valid && taken;
    assign redirect = resolve && (target[1:0] == 2'b00);
    assign misalign = resolve && (target[1:0] != 2'b00);
    assign link_pc  = ex_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = RUN;
            RUN: begin
                if (misalign)      state_nxt = TRAP;
                else if (redirect) state_nxt = FLUSH;
            end
            FLUSH: if (flush_cnt == 4'd1) state_nxt = RUN;
            TRAP:  state_nxt = TRAP;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state == RUN);
        flush       = (state == FLUSH) || (state == TRAP);
    end

    // Redirect takes priority over an accepted handshake; the accepted word dies in the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc       <= RESET_PC;
            flush_cnt      <= '0;
            redirect_count <= '0;
            trap           <= 1'b0;
            trap_pc        <= '0;
        end else begin
            if (redirect) begin
                fetch_pc  <= target;
                flush_cnt <= 4'(FLUSH_CYCLES);
                if (redirect_count != '1) redirect_count <= redirect_count + 16'd1;
            end else if (fetch_valid && fetch_ready) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (state == FLUSH) flush_cnt <= flush_cnt - 4'd1;
            if (misalign) begin
                trap    <= 1'b1;
                trap_pc <= ex_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized + directed bench for pc_branch_unit against a behavioural PC-flow model.
module tb_pc_branch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned FC       = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [2:0]  ex_kind = '0;
    logic [2:0]  ex_status = '0;
    logic [31:0] ex_imm = '0;
    logic [31:0] ex_base = '0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush;
    logic [31:0] link_pc;
    logic        trap;
    logic [31:0] trap_pc;
    logic [15:0] redirect_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: boot pending, remaining flush cycles, trapped flag, PC, counters.
    bit          m_boot;
    int          m_flush_left;
    bit          m_trapped;
    logic [31:0] m_pc;
    logic [31:0] m_trap_pc;
    int          m_cnt;

    pc_branch_unit #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_kind(ex_kind), .ex_status(ex_status), .ex_imm(ex_imm), .ex_base(ex_base),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .flush(flush), .link_pc(link_pc), .trap(trap), .trap_pc(trap_pc),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_taken(input logic [2:0] kind, input logic [2:0] st);
        bit n, v, z;
        n = st[2]; v = st[1]; z = st[0];
        case (kind)
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n != v;
            3'd4: return n == v;
            3'd5, 3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_boot = 1; m_flush_left = 0; m_trapped = 0;
        m_pc = RESET_PC; m_trap_pc = '0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (m_trapped) return;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (ex_valid && m_taken(ex_kind, ex_status)) begin
            tgt = (ex_kind == 3'd6) ? ((ex_base + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
            if (tgt % 4 == 0) begin
                m_pc = tgt;
                m_flush_left = FC;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_trapped = 1;
                m_trap_pc = ex_pc;
                if (fetch_ready) m_pc = m_pc + 4;
            end
        end else if (fetch_ready) begin
            m_pc = m_pc + 4;
        end
    endtask

    task automatic check_outputs();
        bit fv;
        fv = !m_boot && !m_trapped && (m_flush_left == 0);
        check("fetch_valid", 32'(fetch_valid), 32'(fv));
        if (fv || m_flush_left > 0) check("fetch_pc", fetch_pc, m_pc);
        check("flush", 32'(flush), 32'(m_trapped || m_flush_left > 0));
        check("trap", 32'(trap), 32'(m_trapped));
        check("trap_pc", trap_pc, m_trap_pc);
        check("redirect_count", 32'(redirect_count), 32'(m_cnt));
    endtask

    // Called at a negedge: drive, check link_pc, advance one clock, check registered outputs.
    task automatic step(input logic v, input logic [2:0] k, input logic [2:0] st,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] base, input logic rdy);
        ex_valid = v; ex_kind = k; ex_status = st; ex_pc = pc;
        ex_imm = imm; ex_base = base; fetch_ready = rdy;
        #1 check("link_pc", link_pc, pc + 32'd4);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fv"}, 32'(fetch_valid), 32'd0);
        check({tag, "_pc"}, fetch_pc, RESET_PC);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_trap"}, 32'(trap), 32'd0);
        check({tag, "_trap_pc"}, trap_pc, 32'd0);
        check({tag, "_cnt"}, 32'(redirect_count), 32'd0);
    endtask

    // Asserts reset mid-cycle, checks immediate reset values, releases on a negedge.
    task automatic do_reset();
        ex_valid = 0; fetch_ready = 0;
        #2 rst_n = 0;
        #1 check_reset_values("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1 check("boot_fv", 32'(fetch_valid), 32'd0);
    endtask

    initial begin
        logic        v, rdy;
        logic [2:0]  k, st;
        logic [31:0] pc, imm, base;

        model_reset();
        @(negedge clk);
        do_reset();

        // Sequential fetch 0,4,8 then stall at 0x10.
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("pc_before_stall", fetch_pc, 32'h10);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("pc_held", fetch_pc, 32'h10);
        check("fv_held", 32'(fetch_valid), 32'd1);
        idle(1'b1);
        check("pc_after_stall", fetch_pc, 32'h14);

        // Taken BEQ.
        step(1'b1, 3'd1, 3'b001, 32'h20, 32'h40, 32'h0, 1'b1);
        check("beq_target", fetch_pc, 32'h60);
        check("beq_flush", 32'(flush), 32'd1);
        check("beq_cnt", 32'(redirect_count), 32'd1);
        idle(1'b1);
        idle(1'b1);
        check("beq_resume_fv", 32'(fetch_valid), 32'd1);
        check("beq_resume_pc", fetch_pc, 32'h60);

        // BEQ not taken, BLT not taken, BGE taken.
        step(1'b1, 3'd1, 3'b000, 32'h60, 32'h100, 32'h0, 1'b1);
        check("beq_nt_flush", 32'(flush), 32'd0);
        step(1'b1, 3'd3, 3'b110, 32'h64, 32'h100, 32'h0, 1'b1);
        check("blt_nt_flush", 32'(flush), 32'd0);
        step(1'b1, 3'd4, 3'b110, 32'h68, 32'h100, 32'h0, 1'b1);
        check("bge_target", fetch_pc, 32'h168);
        idle(1'b1);
        idle(1'b1);

        // Misaligned JALR -> trap, sticky until reset.
        step(1'b1, 3'd6, 3'b000, 32'h16C, 32'h0, 32'h1003, 1'b1);
        check("jalr_trap", 32'(trap), 32'd1);
        check("jalr_trap_pc", trap_pc, 32'h16C);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd5, 3'b000, 32'h200, 32'h8, 32'h0, 1'b1);
        check("trap_fv_low", 32'(fetch_valid), 32'd0);
        do_reset();

        // Redirect with accepted fetch, then reset mid-FLUSH.
        idle(1'b1);
        step(1'b1, 3'd5, 3'b000, 32'h0, 32'h80, 32'h0, 1'b1);
        check("jal_target", fetch_pc, 32'h80);
        do_reset();

        // Saturation of the redirect counter.
        idle(1'b1);
        force dut.redirect_count = 16'hFFFE;
        #1 release dut.redirect_count;
        m_cnt = 16'hFFFE;
        step(1'b1, 3'd5, 3'b000, 32'h4, 32'h10, 32'h0, 1'b1);
        check("sat_ffff", 32'(redirect_count), 32'h0000_FFFF);
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 3'd5, 3'b000, 32'h14, 32'h10, 32'h0, 1'b1);
        check("sat_hold", 32'(redirect_count), 32'h0000_FFFF);
        idle(1'b1);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 2) != 0);
            k    = 3'($urandom_range(0, 7));
            st   = 3'($urandom_range(0, 7));
            pc   = $urandom & 32'hFFFF_FFFC;
            imm  = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            base = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rdy  = ($urandom_range(0, 3) != 0);
            step(v, k, st, pc, imm, base, rdy);
            if (m_trapped && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
